// File: rtl/serial_transmitter.sv
// serial_transmitter
//   Buffers 7-bit words in a small FIFO and sends each one as a serial frame,
//   one bit per clock: start (0), d0..d6 (LSB first), even parity, stop (1),
//   then IDLE_BITS idle-high gap cycles.
//
// Handshake: a word is accepted on a rising edge where valid_in && ready_out.
//   ready_out is combinational and is low while the FIFO is full or rstn is
//   low. The producer may hold valid_in high indefinitely; an unaccepted word
//   is simply ignored and must be re-presented.
//
// Ports
//   clk        in   rising-edge clock
//   rstn       in   synchronous active-low reset (flushes FIFO, aborts frame)
//   data_in    in   [6:0] word to transmit
//   valid_in   in   data_in valid
//   ready_out  out  FIFO can accept a word (combinational)
//   serial_out out  registered serial line, idles high
//   busy       out  registered, high whenever the FSM is not IDLE
//   fifo_count out  registered number of buffered words
module serial_transmitter #(
   parameter int DEPTH     = 4,
   parameter int IDLE_BITS = 1
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [6:0]                   data_in,
   input  logic                         valid_in,
   output logic                         ready_out,
   output logic                         serial_out,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   // Gap counter value on the last gap cycle; unused when IDLE_BITS = 0.
   localparam logic [3:0] GAP_LAST = (IDLE_BITS == 0) ? 4'd0 : 4'(IDLE_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_GAP
   } state_t;

   state_t          state_q, state_d;
   logic [6:0]      shift_q, shift_d;
   logic            parity_q, parity_d;
   logic [2:0]      idx_q, idx_d;
   logic [3:0]      gap_q, gap_d;
   logic            serial_q, serial_d;
   logic            busy_q, busy_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [6:0]      mem_q [DEPTH];

   logic            push;
   logic            pop;
   logic [6:0]      head;

   assign ready_out  = (count_q != CW'(DEPTH)) && rstn;
   assign push       = valid_in && ready_out;
   // Pop is decided on the count before the edge, so a word pushed into an
   // empty FIFO is only popped on the following edge.
   assign pop        = (state_q == S_IDLE) && (count_q != '0);
   assign head       = mem_q[rd_ptr_q];

   assign serial_out = serial_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;

   // FIFO bookkeeping; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Frame FSM. serial_d/busy_d describe the state being entered so the
   // registered outputs line up with the state on the same edge.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      idx_d    = idx_q;
      gap_d    = gap_q;
      serial_d = serial_q;
      busy_d   = busy_q;
      case (state_q)
         S_IDLE: begin
            serial_d = 1'b1;
            busy_d   = 1'b0;
            if (pop) begin
               state_d  = S_START;
               shift_d  = head;
               parity_d = ^head;
               serial_d = 1'b0;
               busy_d   = 1'b1;
            end
         end
         S_START: begin
            state_d  = S_DATA;
            idx_d    = 3'd0;
            serial_d = shift_q[0];
         end
         S_DATA: begin
            if (idx_q == 3'd6) begin
               state_d  = S_PARITY;
               serial_d = parity_q;
            end else begin
               idx_d    = idx_q + 3'd1;
               serial_d = shift_q[idx_q + 3'd1];
            end
         end
         S_PARITY: begin
            state_d  = S_STOP;
            serial_d = 1'b1;
         end
         S_STOP: begin
            serial_d = 1'b1;
            if (IDLE_BITS == 0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d = S_GAP;
               gap_d   = 4'd0;
            end
         end
         S_GAP: begin
            serial_d = 1'b1;
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            serial_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         shift_q  <= 7'd0;
         parity_q <= 1'b0;
         idx_q    <= 3'd0;
         gap_q    <= 4'd0;
         serial_q <= 1'b1;
         busy_q   <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         idx_q    <= idx_d;
         gap_q    <= gap_d;
         serial_q <= serial_d;
         busy_q   <= busy_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: push is gated by rstn and entries are only read
   // after being written.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_in;
   end

endmodule
